// File: rtl/hs32_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hs32_bus_arb_pkg
// Purpose : Shared state encoding and constants for the hs32 bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package hs32_bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_TIMEOUT_DEFAULT = 255;
    localparam int ARB_DW              = 32;

    localparam int ARB_M_CPU = 0;
    localparam int ARB_M_WB  = 1;

endpackage
`default_nettype wire

// File: rtl/hs32_bus_arb_if.sv
`default_nettype none
// ============================================================================
// Module  : hs32_bus_arb_if
// Purpose : Native hs32 stb/ack bus bundle for NM masters (NM=1 for a plain bus).
// Revision: 1.0 - initial release
// ============================================================================
interface hs32_bus_arb_if
    import hs32_bus_arb_pkg::*;
#(
    parameter int NM = 1
);
    logic [NM-1:0]        stb;
    logic [NM-1:0]        rw;
    logic [NM*ARB_DW-1:0] addr;
    logic [NM*ARB_DW-1:0] dtw;
    logic [NM-1:0]        ack;
    logic [NM-1:0]        err;
    logic [ARB_DW-1:0]    dtr;

    modport master (
        output stb, rw, addr, dtw,
        input  ack, err, dtr
    );

    modport slave (
        input  stb, rw, addr, dtw,
        output ack, err, dtr
    );
endinterface
`default_nettype wire

// File: rtl/hs32_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : hs32_rr_pick
// Purpose : Combinational round-robin picker: first requester after last.
// Revision: 1.0 - initial release
// ============================================================================
module hs32_rr_pick #(
    parameter  int NM = 2,
    localparam int IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] winner_o,
    output logic          any_o
);

    logic [NM-1:0] w_rot;
    int            w_ofs;
    int            w_sum;

    always_comb begin
        w_ofs = 0;
        w_sum = 0;
        // Rotating the doubled vector puts the index just after last at bit 0
        w_rot = NM'({req_i, req_i} >> (int'(last_i) + 1));
        for (int k = NM - 1; k >= 0; k--) begin
            if (w_rot[k]) w_ofs = k;
        end
        w_sum = int'(last_i) + 1 + w_ofs;
        if (w_sum >= NM) w_sum = w_sum - NM;
        winner_o = IW'(w_sum);
        any_o    = |req_i;
    end

endmodule
`default_nettype wire

// File: rtl/hs32_bus_arb.sv
`default_nettype none
// ============================================================================
// Module  : hs32_bus_arb
// Purpose : Round-robin arbiter for the shared hs32 bus with access timeout.
// Revision: 1.0 - initial release
// ============================================================================
module hs32_bus_arb
    import hs32_bus_arb_pkg::*;
#(
    parameter  int NM      = 2,
    parameter  int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    localparam int IW      = (NM > 1) ? $clog2(NM) : 1,
    localparam int TW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    hs32_bus_arb_if.slave         m,
    hs32_bus_arb_if.master        s,
    input  logic                  force_en,
    input  logic [IW-1:0]         force_sel,
    output logic [NM-1:0]         grant,
    output logic                  busy
);

    localparam logic [TW-1:0] TCNT_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [TW-1:0] TCNT_MAX  = {TW{1'b1}};

    arb_state_e    state_q, state_d;
    logic [IW-1:0] g_q, g_d;
    logic [IW-1:0] last_q, last_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic [NM-1:0] w_elig;
    logic [IW-1:0] w_winner;
    logic          w_any;
    logic          w_tmo;

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            w_elig[i] = m.stb[i] & (~force_en | (force_sel == IW'(i)));
        end
    end

    hs32_rr_pick #(.NM(NM)) u_pick (
        .req_i    (w_elig),
        .last_i   (last_q),
        .winner_o (w_winner),
        .any_o    (w_any)
    );

    assign w_tmo = (TIMEOUT != 0) && (tcnt_q == TCNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            g_q     <= '0;
            last_q  <= IW'(NM - 1);
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        last_d  = last_q;
        tcnt_d  = tcnt_q;
        s.stb   = '0;
        s.rw    = '0;
        s.addr  = '0;
        s.dtw   = '0;
        m.ack   = '0;
        m.err   = '0;
        m.dtr   = '0;
        grant   = '0;
        busy    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (w_any) begin
                    g_d     = w_winner;
                    tcnt_d  = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                busy       = 1'b1;
                s.stb      = 1'b1;
                s.rw       = m.rw[g_q];
                s.addr     = m.addr[int'(g_q) * ARB_DW +: ARB_DW];
                s.dtw      = m.dtw[int'(g_q) * ARB_DW +: ARB_DW];
                grant[g_q] = 1'b1;
                m.dtr      = s.dtr;
                // A master that dropped stb mid-access is never acked
                if (s.ack[0]) begin
                    m.ack[g_q] = m.stb[g_q] & ~reset;
                    last_d     = g_q;
                    state_d    = ARB_IDLE;
                end else if (w_tmo) begin
                    m.ack[g_q] = m.stb[g_q] & ~reset;
                    m.err[g_q] = m.stb[g_q] & ~reset;
                    m.dtr      = '0;
                    last_d     = g_q;
                    state_d    = ARB_IDLE;
                end else if (tcnt_q != TCNT_MAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_hs32_bus_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_hs32_bus_arb
// Purpose : Randomized self-checking bench for hs32_bus_arb against a
//           transaction-level ownership model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hs32_bus_arb;
    import hs32_bus_arb_pkg::*;

    localparam int NM  = 2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          force_en;
    logic [0:0]    force_sel;
    logic [NM-1:0] grant;
    logic          busy;

    hs32_bus_arb_if #(.NM(NM)) m_if ();
    hs32_bus_arb_if #(.NM(1))  s_if ();

    hs32_bus_arb #(.NM(NM), .TIMEOUT(TMO)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .m         (m_if),
        .s         (s_if),
        .force_en  (force_en),
        .force_sel (force_sel),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who owns the bus, for how many cycles, and who was served last
    int            owner;
    int            age;
    int            last;
    int            phase;
    logic [NM-1:0] ack_seen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic new_payload(input int i);
        m_if.rw[i]               = 1'($urandom_range(1));
        m_if.addr[i*32 +: 32]    = $urandom;
        m_if.dtw[i*32 +: 32]     = $urandom;
    endtask

    task automatic drive();
        reset = ($urandom_range(255) == 0);
        for (int i = 0; i < NM; i++) begin
            if (m_if.stb[i]) begin
                if (ack_seen[i]) begin
                    if (phase == 2 || $urandom_range(3) != 0) new_payload(i);
                    else m_if.stb[i] = 1'b0;
                end else if ($urandom_range(63) == 0) begin
                    m_if.stb[i] = 1'b0;
                end
            end else if (phase == 2 || $urandom_range(2) == 0) begin
                m_if.stb[i] = 1'b1;
                new_payload(i);
            end
        end
        if ($urandom_range(49) == 0) begin
            force_en  = (phase != 2) && ($urandom_range(2) == 0);
            force_sel = 1'($urandom_range(1));
        end
        s_if.dtr = $urandom;
        case (phase)
            0:       s_if.ack[0] = ($urandom_range(3) == 0);
            1:       s_if.ack[0] = ($urandom_range(15) == 0);
            default: s_if.ack[0] = 1'b1;
        endcase
    endtask

    task automatic check_cycle();
        logic [NM-1:0] e_grant;
        logic [NM-1:0] e_ack;
        logic [NM-1:0] e_err;
        bit            hit;
        bit            tmo;
        bit            found;
        int            cand;

        if (reset) begin
            check("ack_in_reset", 64'(m_if.ack), 64'(0));
            check("err_in_reset", 64'(m_if.err), 64'(0));
            owner    = -1;
            last     = NM - 1;
            ack_seen = '0;
            return;
        end

        e_grant = '0;
        e_ack   = '0;
        e_err   = '0;
        if (owner < 0) begin
            check("s_stb_idle", 64'(s_if.stb), 64'(0));
            check("busy_idle",  64'(busy),     64'(0));
            check("grant_idle", 64'(grant),    64'(0));
            check("ack_idle",   64'(m_if.ack), 64'(0));
            check("err_idle",   64'(m_if.err), 64'(0));
            found = 0;
            for (int k = 1; k <= NM; k++) begin
                cand = (last + k) % NM;
                if (!found && m_if.stb[cand] && (!force_en || int'(force_sel) == cand)) begin
                    found = 1;
                    owner = cand;
                    age   = 1;
                end
            end
            ack_seen = '0;
        end else begin
            tmo = (age == TMO) && !s_if.ack[0];
            hit = s_if.ack[0] || (age == TMO);
            e_grant[owner] = 1'b1;
            e_ack[owner]   = hit && m_if.stb[owner];
            e_err[owner]   = tmo && m_if.stb[owner];
            check("s_stb_busy", 64'(s_if.stb),  64'(1));
            check("busy_busy",  64'(busy),      64'(1));
            check("grant",      64'(grant),     64'(e_grant));
            check("s_rw",       64'(s_if.rw),   64'(m_if.rw[owner]));
            check("s_addr",     64'(s_if.addr), 64'(m_if.addr[owner*32 +: 32]));
            check("s_dtw",      64'(s_if.dtw),  64'(m_if.dtw[owner*32 +: 32]));
            check("m_ack",      64'(m_if.ack),  64'(e_ack));
            check("m_err",      64'(m_if.err),  64'(e_err));
            check("m_dtr",      64'(m_if.dtr),  tmo ? 64'(0) : 64'(s_if.dtr));
            ack_seen = e_ack;
            if (hit) begin
                last  = owner;
                owner = -1;
            end else begin
                age++;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        force_en    = 1'b0;
        force_sel   = '0;
        m_if.stb    = '0;
        m_if.rw     = '0;
        m_if.addr   = '0;
        m_if.dtw    = '0;
        s_if.ack    = '0;
        s_if.err    = '0;
        s_if.dtr    = '0;
        ack_seen    = '0;
        owner       = -1;
        age         = 0;
        last        = NM - 1;
        phase       = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_stb", 64'(s_if.stb), 64'(0));
        check("rst_grant", 64'(grant),    64'(0));
        check("rst_busy",  64'(busy),     64'(0));
        check("rst_ack",   64'(m_if.ack), 64'(0));
        check("rst_err",   64'(m_if.err), 64'(0));

        // Phase 0: mixed slave latency; 1: mostly dead slave; 2: zero-wait, continuous
        for (int p = 0; p < 3; p++) begin
            phase = p;
            for (int c = 0; c < 600; c++) begin
                drive();
                #4;
                check_cycle();
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hs32_bus_arb.md
# hs32_bus_arb

Round-robin arbiter sharing the single internal hs32 memory/MMIO bus (interconnect + SRAM controller) between multiple bus masters, CPU core and Caravel Wishbone host first, with room for a future DMA. It replaces the static LA-driven bus mux in the core top level. Each master uses the native hs32 stb/ack handshake. The arbiter adds a per-transaction timeout that terminates hung accesses with an error pulse, so an unmapped or dead slave can no longer stall the CPU forever.

## Interface
- NM, 2: number of masters; index 0 = CPU, 1 = Wishbone host.
- TIMEOUT, 255: cycles a granted access may wait for s_ack; 0 disables the timeout.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m_stb  in  NM  per-master request; held until its m_ack.
- m_rw  in  NM  per-master write enable (1 = write).
- m_addr  in  NM*32  per-master address; master i uses bits [32i+31:32i].
- m_dtw  in  NM*32  per-master write data.
- m_ack  out  NM  per-master completion pulse.
- m_err  out  NM  per-master error pulse, coincident with m_ack on timeout.
- m_dtr  out  32  read data, shared by all masters; valid only with m_ack.
- force_en  in  1  restrict arbitration to master force_sel (replaces bus_hold).
- force_sel  in  $clog2(NM)  forced master index.
- s_stb, s_rw, s_addr[32], s_dtw[32]  out  to interconnect.
- s_ack  in  1; s_dtr  in  32  from interconnect.
- grant  out  NM  one-hot current owner; 0 when idle.
- busy  out  1  FSM in BUSY.

## Operation
- FSM has two states, IDLE and BUSY, plus registers g (granted index), last (previous winner), and tcnt (timeout counter).
- IDLE:
  - Eligible set is m_stb, masked to force_sel when force_en=1.
  - If the set is non-empty, the winner is the first eligible index after last, modulo NM.
  - Register g ← winner, clear tcnt, go to BUSY.
- BUSY:
  - Drive s_stb=1; s_rw/s_addr/s_dtw come from master g.
  - grant = onehot(g).
  - m_dtr = s_dtr.
- BUSY with s_ack=1:
  - m_ack[g]=1 in the same cycle (combinational).
  - last ← g; go to IDLE.
- BUSY with s_ack=0 and TIMEOUT≠0 and tcnt==TIMEOUT-1:
  - m_ack[g]=1, m_err[g]=1, m_dtr=0 for that cycle.
  - s_stb drops next cycle; last ← g; go to IDLE.
- Otherwise in BUSY, tcnt increments; it saturates and never wraps.
- s_ack received in IDLE (a late ack after timeout) is ignored.
- force_en never preempts a transaction in BUSY; it takes effect at the next arbitration.
- A master dropping m_stb while granted is a protocol violation. The arbiter keeps s_stb asserted until s_ack or timeout, and no m_ack goes to a master whose stb is low.
- Ungranted masters see m_ack=0 and m_err=0.

## Timing
- Reset values:
  - state=IDLE, g=0, tcnt=0.
  - last=NM-1, so master 0 wins the first contention.
  - s_stb=0, m_ack=0, m_err=0, grant=0, busy=0.
- Reset asserted mid-transaction aborts it immediately; no ack or err is issued.
- Latency: m_stb rising at edge N gives s_stb high from cycle N+1. Zero-wait slave: m_ack in cycle N+1.
- Minimum one IDLE cycle between transactions, so peak throughput is 1 access per 2 cycles.
- Fairness: with all NM masters requesting continuously, each master is served once per NM transactions.
- Timeout fires exactly TIMEOUT cycles after s_stb first asserts.
- Simultaneous s_ack and timeout in the same cycle: the ack wins, m_err=0, data is delivered.
- m_ack and m_err are single-cycle pulses.

## Structure
- Shared defines header holds:
  - state encoding (ARB_IDLE=1'b0, ARB_BUSY=1'b1);
  - default TIMEOUT;
  - master index constants (ARB_M_CPU=0, ARB_M_WB=1).
- Sub-module hs32_rr_pick: purely combinational round-robin picker.
  - Inputs: req[NM], last index.
  - Outputs: winner index, any.
  - Implemented with a double-width rotate-and-priority scheme.
- Top arbiter holds the FSM, tcnt (width $clog2(TIMEOUT+1)), and the output muxing.

## Test plan
- Single CPU read, slave acks after 2 cycles with s_dtr=0xDEADBEEF → s_stb high cycles 1–3, m_ack[0] in cycle 3 with m_dtr=0xDEADBEEF, grant=01, m_err=0.
- Both masters request continuously, zero-wait slave → grant order 0,1,0,1…; each master gets an ack every 4 cycles.
- force_en=1, force_sel=1, both requesting → only master 1 is served; master 0 gets no ack until force_en drops, then is served next.
- TIMEOUT=8, slave never acks → m_ack[g]=m_err[g]=1 exactly 8 cycles after s_stb rises, m_dtr=0; a late s_ack 3 cycles later is ignored.
- s_ack and the timeout cycle coincide → m_ack=1, m_err=0, data passed through.
- reset pulsed while BUSY → next cycle s_stb=0, grant=0, busy=0, no m_ack; after release, master 0 wins contention first.
